mac_test_sequencer: RTL and testbench

Sequences the unpipelined int8 MAC unit through a stored vector set during self-test. For each vector it addresses the vector memory, loads operands A, B, C and the expected MAC value, and issues A/B/C to the MAC over an enable/ready handshake. It then waits for the result, compares it against the expected value, and keeps pass/fail statistics. It sits between the vector-memory reader and the MAC datapath and is started and monitored by the test harness.

---
 rtl/mac_test_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_mac_test_sequencer.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_test_sequencer.sv
// Self-test sequencer for the unpipelined int8 MAC: fetches each stored
// vector, issues it to the MAC, waits for the result (with timeout),
// compares it bitwise against the stored expectation and keeps statistics.
module mac_test_sequencer #(
  parameter int NUM_VECTORS = 1000,
  parameter int IDX_W       = 10,
  parameter int TIMEOUT     = 64
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             start,
  input  logic             abort,
  output logic             vec_rd,
  output logic [IDX_W-1:0] vec_idx,
  input  logic [7:0]       vec_a,
  input  logic [7:0]       vec_b,
  input  logic [31:0]      vec_c,
  input  logic [31:0]      vec_mac,
  output logic [7:0]       mac_a,
  output logic [7:0]       mac_b,
  output logic [31:0]      mac_c,
  output logic             mac_en,
  input  logic             mac_rdy,
  input  logic             mac_valid,
  input  logic [31:0]      mac_result,
  output logic             busy,
  output logic             done,
  output logic             mismatch,
  output logic             timeout_err,
  output logic [15:0]      pass_count,
  output logic [15:0]      fail_count,
  output logic [IDX_W-1:0] first_fail_idx
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_ISSUE, S_WAIT, S_CHECK, S_DONE
  } state_e;

  localparam int                 CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(NUM_VECTORS - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q;
  logic [7:0]         mac_a_q, mac_b_q;
  logic [31:0]        mac_c_q, exp_q, res_q;
  logic               tmo_q;
  logic [CNT_W-1:0]   wcnt_q;
  logic [15:0]        pass_q, fail_q;
  logic [IDX_W-1:0]   ffi_q;
  logic               terr_q;

  logic accept, load_en, cap_valid, cap_tmo, chk_en, pass_now;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // A timed-out vector always fails, whatever stale value sits in res_q.
  assign pass_now = (res_q == exp_q) && !tmo_q;

  // State register
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state and strobe decode; abort overrides everything, including start
  always_comb begin
    state_d   = state_q;
    vec_rd    = 1'b0;
    mac_en    = 1'b0;
    mismatch  = 1'b0;
    accept    = 1'b0;
    load_en   = 1'b0;
    cap_valid = 1'b0;
    cap_tmo   = 1'b0;
    chk_en    = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            accept  = 1'b1;
            state_d = S_FETCH;
          end
        end
        S_FETCH: begin
          vec_rd  = 1'b1;
          state_d = S_LOAD;
        end
        S_LOAD: begin
          load_en = 1'b1;
          state_d = S_ISSUE;
        end
        S_ISSUE: begin
          if (mac_rdy) begin
            mac_en  = 1'b1;
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          // A result arriving on the timeout cycle still counts as a result.
          if (mac_valid) begin
            cap_valid = 1'b1;
            state_d   = S_CHECK;
          end else if (wcnt_q == CNT_LAST) begin
            cap_tmo = 1'b1;
            state_d = S_CHECK;
          end
        end
        S_CHECK: begin
          chk_en   = 1'b1;
          mismatch = !pass_now;
          state_d  = (idx_q == IDX_LAST) ? S_DONE : S_FETCH;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Operand hold registers, result capture, wait counter and run statistics
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      idx_q   <= '0;
      mac_a_q <= '0;
      mac_b_q <= '0;
      mac_c_q <= '0;
      exp_q   <= '0;
      res_q   <= '0;
      tmo_q   <= 1'b0;
      wcnt_q  <= '0;
      pass_q  <= '0;
      fail_q  <= '0;
      ffi_q   <= '0;
      terr_q  <= 1'b0;
    end else begin
      if (accept) begin
        idx_q  <= '0;
        pass_q <= '0;
        fail_q <= '0;
        ffi_q  <= '0;
        terr_q <= 1'b0;
      end
      if (load_en) begin
        mac_a_q <= vec_a;
        mac_b_q <= vec_b;
        mac_c_q <= vec_c;
        exp_q   <= vec_mac;
      end
      if (mac_en) begin
        wcnt_q <= '0;
        tmo_q  <= 1'b0;
      end else if (state_q == S_WAIT) begin
        wcnt_q <= wcnt_q + CNT_W'(1);
      end
      if (cap_valid) res_q <= mac_result;
      if (cap_tmo) begin
        tmo_q  <= 1'b1;
        terr_q <= 1'b1;
      end
      if (chk_en) begin
        if (pass_now) begin
          pass_q <= sat_inc(pass_q);
        end else begin
          fail_q <= sat_inc(fail_q);
          if (fail_q == 16'd0) ffi_q <= idx_q;
        end
        if (idx_q != IDX_LAST) idx_q <= idx_q + IDX_W'(1);
      end
    end
  end

  assign vec_idx        = idx_q;
  assign mac_a          = mac_a_q;
  assign mac_b          = mac_b_q;
  assign mac_c          = mac_c_q;
  assign busy           = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done           = (state_q == S_DONE);
  assign timeout_err    = terr_q;
  assign pass_count     = pass_q;
  assign fail_count     = fail_q;
  assign first_fail_idx = ffi_q;

endmodule

// File: tb/tb_mac_test_sequencer.sv
// Bench for mac_test_sequencer: a vector-memory and MAC responder driven from
// per-vector scenario tables, with expected statistics and run length derived
// from the table by plain arithmetic.
module tb_mac_test_sequencer;

  localparam int NV = 4;
  localparam int TO = 64;
  localparam int IW = 10;

  logic          clk, RST, start, abort;
  logic          vec_rd, mac_en, mac_rdy, mac_valid;
  logic          busy, done, mismatch, timeout_err;
  logic [IW-1:0] vec_idx, first_fail_idx;
  logic [7:0]    vec_a, vec_b, mac_a, mac_b;
  logic [31:0]   vec_c, vec_mac, mac_c, mac_result;
  logic [15:0]   pass_count, fail_count;

  mac_test_sequencer #(.NUM_VECTORS(NV), .IDX_W(IW), .TIMEOUT(TO)) dut (
    .clk(clk), .RST(RST), .start(start), .abort(abort),
    .vec_rd(vec_rd), .vec_idx(vec_idx),
    .vec_a(vec_a), .vec_b(vec_b), .vec_c(vec_c), .vec_mac(vec_mac),
    .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c),
    .mac_en(mac_en), .mac_rdy(mac_rdy), .mac_valid(mac_valid), .mac_result(mac_result),
    .busy(busy), .done(done), .mismatch(mismatch), .timeout_err(timeout_err),
    .pass_count(pass_count), .fail_count(fail_count), .first_fail_idx(first_fail_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scenario table: stored vectors and how the MAC behaves for each one.
  logic [7:0]  mem_a [NV];
  logic [7:0]  mem_b [NV];
  logic [31:0] mem_c [NV];
  logic [31:0] mem_mac [NV];
  logic [31:0] xmask [NV];
  int          lat [NV];
  int          rdyw [NV];
  bit          drop [NV];
  bit          spur [NV];

  int n_chk = 0;
  int n_fail = 0;

  // Monitor state
  bit prev_rd, prev_en, last_rd, last_en, last_mm, stab_arm;
  int prev_idx, stab_i;
  int since = 3;
  int fetch_q[$];
  int en_cnt, en_bad, pw_bad, mm_cnt, stab_bad;

  // Responder state
  int cur_i, rdy_rem, vl;

  function automatic logic [31:0] true_mac(int i);
    int p;
    p = $signed(mem_a[i]) * $signed(mem_b[i]);
    return 32'(p) + mem_c[i];
  endfunction

  function automatic logic [31:0] mac_out(int i);
    return true_mac(i) ^ xmask[i];
  endfunction

  // Mid-cycle observation of DUT strobes
  always @(negedge clk) begin
    prev_rd  = vec_rd;
    prev_en  = mac_en;
    prev_idx = int'(vec_idx);
    if (vec_rd) begin
      fetch_q.push_back(int'(vec_idx));
      stab_arm = 1'b1;
      stab_i   = int'(vec_idx);
      since    = 0;
    end else if (since < 3) begin
      since++;
    end
    if (stab_arm && since >= 2 &&
        ({mac_a, mac_b, mac_c} !== {mem_a[stab_i], mem_b[stab_i], mem_c[stab_i]}))
      stab_bad++;
    if (mac_en) en_cnt++;
    if (mac_en && !mac_rdy) en_bad++;
    if ((vec_rd && last_rd) || (mac_en && last_en) || (mismatch && last_mm)) pw_bad++;
    if (mismatch) mm_cnt++;
    last_rd = vec_rd;
    last_en = mac_en;
    last_mm = mismatch;
  end

  // Vector memory and MAC behaviour, updated just after each rising edge
  always @(posedge clk) begin
    #1;
    mac_valid  = 1'b0;
    mac_result = $urandom;
    if (prev_rd) begin
      cur_i   = prev_idx;
      vec_a   = mem_a[cur_i];
      vec_b   = mem_b[cur_i];
      vec_c   = mem_c[cur_i];
      vec_mac = mem_mac[cur_i];
      rdy_rem = rdyw[cur_i];
      mac_rdy = (rdy_rem == 0);
      if (spur[cur_i]) mac_valid = 1'b1;
    end else begin
      vec_a   = 8'($urandom);
      vec_b   = 8'($urandom);
      vec_c   = $urandom;
      vec_mac = $urandom;
      if (rdy_rem > 0) begin
        mac_rdy = 1'b0;
        rdy_rem--;
      end else begin
        mac_rdy = 1'b1;
      end
    end
    if (prev_en) vl = drop[cur_i] ? 0 : lat[cur_i];
    if (vl == 1) begin
      mac_valid  = 1'b1;
      mac_result = mac_out(cur_i);
    end
    if (vl > 0) vl--;
  end

  task automatic set_ideal();
    for (int i = 0; i < NV; i++) begin
      mem_a[i]   = 8'($urandom);
      mem_b[i]   = 8'($urandom);
      mem_c[i]   = $urandom;
      mem_mac[i] = true_mac(i);
      xmask[i]   = '0;
      lat[i]     = 1;
      rdyw[i]    = 0;
      drop[i]    = 1'b0;
      spur[i]    = 1'b0;
    end
  endtask

  task automatic set_random();
    int r;
    set_ideal();
    for (int i = 0; i < NV; i++) begin
      rdyw[i] = $urandom_range(0, 3);
      spur[i] = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 9);
      if (r < 6)       lat[i] = $urandom_range(1, 4);
      else if (r == 6) lat[i] = TO;
      else if (r == 7) lat[i] = TO + 1;
      else if (r == 8) drop[i] = 1'b1;
      else             lat[i] = $urandom_range(1, TO - 1);
      if ($urandom_range(0, 4) == 0) xmask[i] = 32'h1 << $urandom_range(0, 31);
      if ($urandom_range(0, 5) == 0) mem_mac[i] = mem_mac[i] ^ (32'h1 << $urandom_range(0, 31));
    end
  endtask

  // Full run from an accepted start to done, checked against the table.
  task automatic run_vectors(input string nm, input int inj);
    int n, e_pass, e_fail, e_ffi, e_cyc, w;
    bit e_tmo, tmo;
    e_pass = 0; e_fail = 0; e_ffi = 0; e_cyc = 0; e_tmo = 1'b0;
    for (int i = 0; i < NV; i++) begin
      tmo   = drop[i] || (lat[i] > TO);
      w     = tmo ? TO : lat[i];
      e_cyc = e_cyc + 4 + rdyw[i] + w;
      e_tmo = e_tmo | tmo;
      if (!tmo && mac_out(i) == mem_mac[i]) e_pass++;
      else begin
        if (e_fail == 0) e_ffi = i;
        e_fail++;
      end
    end
    fetch_q.delete();
    en_cnt = 0; en_bad = 0; pw_bad = 0; mm_cnt = 0; stab_bad = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n_chk++;
    if ({busy, done} !== 2'b10) begin
      n_fail++; $display("FAIL %s start_accept: busy,done=%b expected 10", nm, {busy, done});
    end
    n_chk++;
    if ({pass_count, fail_count, first_fail_idx, timeout_err} !== '0) begin
      n_fail++; $display("FAIL %s clear_on_start: pass=%0d fail=%0d ffi=%0d tmo=%b expected all 0",
                         nm, pass_count, fail_count, first_fail_idx, timeout_err);
    end
    n = 0;
    while (done !== 1'b1 && n < 3000) begin
      start = (n == inj);
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    n_chk++;
    if (n !== e_cyc) begin
      n_fail++; $display("FAIL %s done_latency: got %0d cycles expected %0d", nm, n, e_cyc);
    end
    n_chk++;
    if (pass_count !== 16'(e_pass)) begin
      n_fail++; $display("FAIL %s pass_count: got %0d expected %0d", nm, pass_count, e_pass);
    end
    n_chk++;
    if (fail_count !== 16'(e_fail)) begin
      n_fail++; $display("FAIL %s fail_count: got %0d expected %0d", nm, fail_count, e_fail);
    end
    n_chk++;
    if (first_fail_idx !== IW'(e_ffi)) begin
      n_fail++; $display("FAIL %s first_fail_idx: got %0d expected %0d", nm, first_fail_idx, e_ffi);
    end
    n_chk++;
    if (timeout_err !== e_tmo) begin
      n_fail++; $display("FAIL %s timeout_err: got %b expected %b", nm, timeout_err, e_tmo);
    end
    n_chk++;
    if (mm_cnt !== e_fail) begin
      n_fail++; $display("FAIL %s mismatch_pulses: got %0d expected %0d", nm, mm_cnt, e_fail);
    end
    n_chk++;
    if (fetch_q.size() !== NV) begin
      n_fail++; $display("FAIL %s fetch_count: got %0d expected %0d", nm, fetch_q.size(), NV);
    end
    for (int i = 0; i < fetch_q.size() && i < NV; i++) begin
      n_chk++;
      if (fetch_q[i] !== i) begin
        n_fail++; $display("FAIL %s vec_idx_seq[%0d]: got %0d expected %0d", nm, i, fetch_q[i], i);
      end
    end
    n_chk++;
    if ({en_bad, pw_bad, stab_bad} !== '0) begin
      n_fail++; $display("FAIL %s protocol: en_without_rdy=%0d long_pulses=%0d operand_changes=%0d expected 0",
                         nm, en_bad, pw_bad, stab_bad);
    end
    n_chk++;
    if ({busy, done} !== 2'b01) begin
      n_fail++; $display("FAIL %s end_state: busy,done=%b expected 01", nm, {busy, done});
    end
    stab_arm = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b0; start = 1'b0; abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if ({busy, done, vec_rd, mac_en, mismatch, timeout_err} !== 6'b0) begin
      n_fail++; $display("FAIL reset_flags: busy,done,rd,en,mm,tmo=%b expected 000000",
                         {busy, done, vec_rd, mac_en, mismatch, timeout_err});
    end
    n_chk++;
    if ({pass_count, fail_count, first_fail_idx, vec_idx} !== '0) begin
      n_fail++; $display("FAIL reset_counts: pass=%0d fail=%0d ffi=%0d idx=%0d expected 0",
                         pass_count, fail_count, first_fail_idx, vec_idx);
    end
    n_chk++;
    if ({mac_a, mac_b, mac_c} !== '0) begin
      n_fail++; $display("FAIL reset_operands: a=%h b=%h c=%h expected 0", mac_a, mac_b, mac_c);
    end
    RST = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if ({busy, done, vec_rd} !== 3'b0) begin
      n_fail++; $display("FAIL idle_without_start: busy,done,rd=%b expected 000", {busy, done, vec_rd});
    end
  endtask

  task automatic test_ideal();
    set_ideal();
    run_vectors("ideal", 7);
  endtask

  task automatic test_mismatch();
    set_ideal();
    mem_a[2] = 8'h00; mem_b[2] = 8'h00; mem_c[2] = 32'h0000_0010; mem_mac[2] = 32'h0000_0011;
    run_vectors("mismatch", -1);
  endtask

  task automatic test_timeout();
    set_ideal();
    drop[1] = 1'b1;
    run_vectors("timeout", -1);
  endtask

  task automatic test_rdy_hold();
    set_ideal();
    rdyw[1] = 10;
    run_vectors("rdy_hold", -1);
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      set_random();
      run_vectors($sformatf("random%0d", r), $urandom_range(1, 12));
    end
  endtask

  task automatic test_abort();
    int n;
    set_ideal();
    lat[2] = 30;
    en_cnt = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    while (en_cnt < 3 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    n_chk++;
    if (en_cnt < 3) begin
      n_fail++; $display("FAIL abort_reach_wait: issues=%0d expected 3", en_cnt);
    end
    repeat (3) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    stab_arm = 1'b0;
    n_chk++;
    if ({busy, done, vec_rd, mac_en} !== 4'b0) begin
      n_fail++; $display("FAIL abort_idle: busy,done,rd,en=%b expected 0000", {busy, done, vec_rd, mac_en});
    end
    n_chk++;
    if ({pass_count, fail_count} !== {16'd2, 16'd0}) begin
      n_fail++; $display("FAIL abort_counts_kept: pass=%0d fail=%0d expected 2 0", pass_count, fail_count);
    end
    repeat (40) @(posedge clk);
    #1 start = 1'b1; abort = 1'b1;
    @(posedge clk); #1 start = 1'b0; abort = 1'b0;
    n_chk++;
    if ({busy, pass_count} !== {1'b0, 16'd2}) begin
      n_fail++; $display("FAIL abort_over_start: busy=%b pass=%0d expected 0 2", busy, pass_count);
    end
    set_ideal();
    run_vectors("abort_restart", -1);
  endtask

  task automatic test_reset_mid();
    int n;
    set_ideal();
    lat[1] = 40;
    en_cnt = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    while (en_cnt < 2 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    n_chk++;
    if (en_cnt < 2) begin
      n_fail++; $display("FAIL rst_reach_wait: issues=%0d expected 2", en_cnt);
    end
    repeat (4) @(posedge clk);
    #3;
    stab_arm = 1'b0;
    RST = 1'b0;
    #1;
    n_chk++;
    if ({busy, done, vec_rd, mac_en, mismatch, timeout_err} !== 6'b0) begin
      n_fail++; $display("FAIL rst_async_flags: busy,done,rd,en,mm,tmo=%b expected 000000",
                         {busy, done, vec_rd, mac_en, mismatch, timeout_err});
    end
    n_chk++;
    if ({pass_count, fail_count, vec_idx, mac_a, mac_b, mac_c} !== '0) begin
      n_fail++; $display("FAIL rst_async_values: pass=%0d fail=%0d idx=%0d a=%h b=%h c=%h expected 0",
                         pass_count, fail_count, vec_idx, mac_a, mac_b, mac_c);
    end
    repeat (2) @(posedge clk);
    #1 RST = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if ({busy, done, pass_count, fail_count} !== '0) begin
      n_fail++; $display("FAIL rst_release: busy=%b done=%b pass=%0d fail=%0d expected 0",
                         busy, done, pass_count, fail_count);
    end
    repeat (50) @(posedge clk);
    set_ideal();
    run_vectors("after_reset", -1);
  endtask

  initial begin
    test_reset();
    test_ideal();
    test_mismatch();
    test_timeout();
    test_rdy_hold();
    test_random();
    test_abort();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
